// File: rtl/io_dev_port.sv
// Device endpoint for the processor's 8-bit I/O handshake ports.
// TX FIFO feeds a 4-phase input handshake; processor writes fill the RX FIFO.
module io_dev_port #(
   parameter int DEPTH = 4,
   parameter int CW    = 3
) (
   input  logic          g_clk,
   input  logic          g_clr,
   input  logic [7:0]    src_data,
   input  logic          src_valid,
   output logic          src_ready,
   output logic [7:0]    input_bus,
   output logic          in_dev_hs,
   input  logic          in_dev_ack,
   input  logic [7:0]    output_bus,
   input  logic          out_stb,
   output logic          out_dev_hs,
   output logic          out_dev_ack,
   output logic [7:0]    sink_data,
   output logic          sink_valid,
   input  logic          sink_ready,
   output logic [CW-1:0] tx_count,
   output logic [CW-1:0] rx_count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   typedef enum logic [1:0] {I_IDLE, I_PRESENT, I_RELEASE} i_state_t;
   typedef enum logic {O_READY, O_ACK} o_state_t;

   i_state_t i_state_q, i_state_d;
   o_state_t o_state_q, o_state_d;

   logic [7:0]    tx_mem_q [DEPTH];
   logic [7:0]    tx_mem_d [DEPTH];
   logic [7:0]    rx_mem_q [DEPTH];
   logic [7:0]    rx_mem_d [DEPTH];
   logic [AW-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
   logic [AW-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
   logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
   logic [7:0]    in_bus_q, in_bus_d;

   logic tx_push, tx_pop, rx_push, rx_pop;

   assign src_ready   = (tx_cnt_q != FULL);
   assign sink_valid  = (rx_cnt_q != '0);
   assign sink_data   = rx_mem_q[rx_rd_q];
   assign tx_count    = tx_cnt_q;
   assign rx_count    = rx_cnt_q;
   assign input_bus   = in_bus_q;
   assign in_dev_hs   = (i_state_q == I_PRESENT);
   assign out_dev_ack = (o_state_q == O_ACK);
   // Ready only derives from registered state and count, never from inputs
   assign out_dev_hs  = (o_state_q == O_READY) && (rx_cnt_q != FULL);

   assign tx_push = src_valid && src_ready;
   assign rx_pop  = sink_ready && sink_valid;

   always_comb begin
      i_state_d = i_state_q;
      in_bus_d  = in_bus_q;
      tx_pop    = 1'b0;
      unique case (i_state_q)
         I_IDLE: begin
            if (tx_cnt_q != '0) begin
               in_bus_d  = tx_mem_q[tx_rd_q];
               i_state_d = I_PRESENT;
            end
         end
         I_PRESENT: begin
            if (in_dev_ack) begin
               tx_pop    = 1'b1;
               i_state_d = I_RELEASE;
            end
         end
         I_RELEASE: begin
            if (!in_dev_ack) i_state_d = I_IDLE;
         end
         default: i_state_d = I_IDLE;
      endcase
   end

   always_comb begin
      o_state_d = o_state_q;
      rx_push   = 1'b0;
      unique case (o_state_q)
         O_READY: begin
            if (out_stb && out_dev_hs) begin
               rx_push   = 1'b1;
               o_state_d = O_ACK;
            end
         end
         O_ACK: begin
            if (!out_stb) o_state_d = O_READY;
         end
         default: o_state_d = O_READY;
      endcase
   end

   always_comb begin
      tx_mem_d = tx_mem_q;
      tx_wr_d  = tx_wr_q;
      tx_rd_d  = tx_rd_q;
      tx_cnt_d = tx_cnt_q;
      if (tx_push) begin
         tx_mem_d[tx_wr_q] = src_data;
         tx_wr_d           = tx_wr_q + AW'(1);
      end
      if (tx_pop) tx_rd_d = tx_rd_q + AW'(1);
      if (tx_push && !tx_pop) tx_cnt_d = tx_cnt_q + CW'(1);
      else if (!tx_push && tx_pop) tx_cnt_d = tx_cnt_q - CW'(1);
   end

   always_comb begin
      rx_mem_d = rx_mem_q;
      rx_wr_d  = rx_wr_q;
      rx_rd_d  = rx_rd_q;
      rx_cnt_d = rx_cnt_q;
      if (rx_push) begin
         rx_mem_d[rx_wr_q] = output_bus;
         rx_wr_d           = rx_wr_q + AW'(1);
      end
      if (rx_pop) rx_rd_d = rx_rd_q + AW'(1);
      if (rx_push && !rx_pop) rx_cnt_d = rx_cnt_q + CW'(1);
      else if (!rx_push && rx_pop) rx_cnt_d = rx_cnt_q - CW'(1);
   end

   always_ff @(posedge g_clk or posedge g_clr) begin
      if (g_clr) begin
         i_state_q <= I_IDLE;
         o_state_q <= O_READY;
         in_bus_q  <= '0;
         tx_wr_q   <= '0;
         tx_rd_q   <= '0;
         tx_cnt_q  <= '0;
         rx_wr_q   <= '0;
         rx_rd_q   <= '0;
         rx_cnt_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            tx_mem_q[i] <= '0;
            rx_mem_q[i] <= '0;
         end
      end else begin
         i_state_q <= i_state_d;
         o_state_q <= o_state_d;
         in_bus_q  <= in_bus_d;
         tx_wr_q   <= tx_wr_d;
         tx_rd_q   <= tx_rd_d;
         tx_cnt_q  <= tx_cnt_d;
         rx_wr_q   <= rx_wr_d;
         rx_rd_q   <= rx_rd_d;
         rx_cnt_q  <= rx_cnt_d;
         tx_mem_q  <= tx_mem_d;
         rx_mem_q  <= rx_mem_d;
      end
   end

endmodule
